// File: rtl/readout_pkg.sv
// readout_pkg: shared definitions for the capture-buffer reader and the capture
// write controller (state encoding, default geometry).
package readout_pkg;

  // Default sample RAM address width (buffer depth = 2**ADDR_W).
  localparam int DEFAULT_ADDR_W  = 11;
  // Default RAM read latency in clock cycles (legal range 1..3).
  localparam int DEFAULT_RAM_LAT = 1;

  // Reader FSM state encoding, shared with the write side for status reporting.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } rd_state_t;

  // Wait-counter terminal value for a given RAM latency.
  function automatic logic [1:0] wait_last(input int ram_lat);
    return 2'(ram_lat - 1);
  endfunction

endpackage

// File: rtl/sample_readout_if.sv
// sample_readout_if: control, RAM-read and MCU-port signals of the sample reader.
// The slave modport is the reader itself; the master modport is its environment
// (trigger logic, sample RAM and MCU port).
interface sample_readout_if #(
  parameter int ADDR_W = readout_pkg::DEFAULT_ADDR_W
);
  // readout control
  logic              Start_Read;
  logic              Abort;
  logic [ADDR_W-1:0] Trig_Addr;
  logic [ADDR_W-1:0] Pretrig;
  logic [ADDR_W:0]   Read_Len;
  logic              Chan_Sel;
  // sample RAM read port
  logic [7:0]        RAM_DATA_A;
  logic [7:0]        RAM_DATA_B;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic              RAM_RD_EN;
  // MCU data port
  logic              MCU_RD;
  logic [7:0]        DATA_OUT;
  logic              Data_Valid;
  logic              Busy;
  logic              Done;

  modport master (
    output Start_Read, Abort, Trig_Addr, Pretrig, Read_Len, Chan_Sel,
    output RAM_DATA_A, RAM_DATA_B, MCU_RD,
    input  RAM_ADDR, RAM_RD_EN, DATA_OUT, Data_Valid, Busy, Done
  );

  modport slave (
    input  Start_Read, Abort, Trig_Addr, Pretrig, Read_Len, Chan_Sel,
    input  RAM_DATA_A, RAM_DATA_B, MCU_RD,
    output RAM_ADDR, RAM_RD_EN, DATA_OUT, Data_Valid, Busy, Done
  );

endinterface

// File: rtl/readout_addr_gen.sv
// readout_addr_gen: start address (trigger minus pretrigger, modulo buffer depth),
// wrapping address increment and remaining-sample counter for the reader.
module readout_addr_gen #(
  parameter int ADDR_W = readout_pkg::DEFAULT_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,       // take start address and length
  input  logic              step,       // one address consumed
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W:0]   read_len,
  output logic [ADDR_W-1:0] addr,
  output logic              cnt_last    // current address is the final one
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  // Next address/count: subtraction and increment both wrap naturally at ADDR_W bits.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = trig_addr - pretrig;
      cnt_d  = read_len;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - (ADDR_W + 1)'(1);
    end
  end

  // Address and count registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr     = addr_q;
  assign cnt_last = (cnt_q == (ADDR_W + 1)'(1));

endmodule

// File: rtl/sample_readout.sv
// sample_readout: after a trigger, streams stored samples from the circular sample
// RAM to the MCU, starting Pretrig samples before the trigger address, one byte per
// MCU_RD strobe.
// Build option: define INTERLEAVE_AB_EN to emit channel A then channel B for every
// address from a single RAM read; otherwise one byte per address chosen by Chan_Sel.
module sample_readout
  import readout_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int RAM_LAT = DEFAULT_RAM_LAT
) (
  input logic CLK,
  input logic RST,
  sample_readout_if.slave bus
);

  localparam logic [1:0] WAIT_LAST = wait_last(RAM_LAT);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]        wait_q, wait_d;
  logic [7:0]        data_q, data_d;
  logic              gen_load, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_addr;
`ifdef INTERLEAVE_AB_EN
  logic [7:0]        data_b_q, data_b_d;   // B byte of the current address
  logic              second_q, second_d;   // B byte is the one on DATA_OUT
  logic              gap_q, gap_d;         // one idle cycle between A and B
`else
  logic              chan_q, chan_d;
`endif

  readout_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .CLK       (CLK),
    .RST       (RST),
    .load      (gen_load),
    .step      (gen_step),
    .trig_addr (trig_q),
    .pretrig   (pretrig_q),
    .read_len  (len_q),
    .addr      (gen_addr),
    .cnt_last  (gen_last)
  );

  // Next-state and datapath control; Abort overrides every state.
  always_comb begin
    state_d    = state_q;
    trig_d     = trig_q;
    pretrig_d  = pretrig_q;
    len_d      = len_q;
    ram_addr_d = ram_addr_q;
    wait_d     = wait_q;
    data_d     = data_q;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
`ifdef INTERLEAVE_AB_EN
    data_b_d   = data_b_q;
    second_d   = second_q;
    gap_d      = gap_q;
`else
    chan_d     = chan_q;
`endif

    if (bus.Abort) begin
      state_d = ST_IDLE;
`ifdef INTERLEAVE_AB_EN
      second_d = 1'b0;
      gap_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Start_Read) begin
            trig_d    = bus.Trig_Addr;
            pretrig_d = bus.Pretrig;
            len_d     = bus.Read_Len;
`ifndef INTERLEAVE_AB_EN
            chan_d    = bus.Chan_Sel;
`endif
            state_d   = ST_SETUP;
          end
        end
        ST_SETUP: begin
          gen_load = 1'b1;
          state_d  = (len_q == '0) ? ST_DONE : ST_FETCH;
        end
        ST_FETCH: begin
          ram_addr_d = gen_addr;
          wait_d     = '0;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
`ifdef INTERLEAVE_AB_EN
            data_d   = bus.RAM_DATA_A;
            data_b_d = bus.RAM_DATA_B;
            second_d = 1'b0;
            gap_d    = 1'b0;
`else
            data_d   = chan_q ? bus.RAM_DATA_B : bus.RAM_DATA_A;
`endif
            state_d  = ST_PRESENT;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
        ST_PRESENT: begin
`ifdef INTERLEAVE_AB_EN
          if (gap_q) begin
            gap_d = 1'b0;
          end else if (bus.MCU_RD) begin
            if (!second_q) begin
              data_d   = data_b_q;
              second_d = 1'b1;
              gap_d    = 1'b1;
            end else begin
              second_d = 1'b0;
              gen_step = 1'b1;
              state_d  = gen_last ? ST_DONE : ST_FETCH;
            end
          end
`else
          if (bus.MCU_RD) begin
            gen_step = 1'b1;
            state_d  = gen_last ? ST_DONE : ST_FETCH;
          end
`endif
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      trig_q     <= '0;
      pretrig_q  <= '0;
      len_q      <= '0;
      ram_addr_q <= '0;
      wait_q     <= '0;
      data_q     <= '0;
`ifdef INTERLEAVE_AB_EN
      data_b_q   <= '0;
      second_q   <= 1'b0;
      gap_q      <= 1'b0;
`else
      chan_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      pretrig_q  <= pretrig_d;
      len_q      <= len_d;
      ram_addr_q <= ram_addr_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
`ifdef INTERLEAVE_AB_EN
      data_b_q   <= data_b_d;
      second_q   <= second_d;
      gap_q      <= gap_d;
`else
      chan_q     <= chan_d;
`endif
    end
  end

  // Outputs decode from registered state; RAM_ADDR holds the last fetched address.
  always_comb begin
    bus.RAM_RD_EN = (state_q == ST_FETCH);
    bus.RAM_ADDR  = (state_q == ST_FETCH) ? gen_addr : ram_addr_q;
    bus.DATA_OUT  = data_q;
`ifdef INTERLEAVE_AB_EN
    bus.Data_Valid = (state_q == ST_PRESENT) && !gap_q;
`else
    bus.Data_Valid = (state_q == ST_PRESENT);
`endif
    bus.Busy      = (state_q != ST_IDLE);
    bus.Done      = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_sample_readout.sv
// tb_sample_readout: table vectors, hand sequences (zero length, stall, abort) and
// random transfers against a behavioural model of the capture-buffer reader.
module tb_sample_readout;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
`ifdef INTERLEAVE_AB_EN
  localparam int BPA   = 2;
`else
  localparam int BPA   = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   fetch_q[$];
  logic [7:0]  mem_a [DEPTH];
  logic [7:0]  mem_b [DEPTH];
  logic [15:0] pipe  [LAT];

  sample_readout_if #(.ADDR_W(AW)) bus();

  sample_readout #(.ADDR_W(AW), .RAM_LAT(LAT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Sample RAM: read registered on RD_EN, then LAT-1 further pipeline stages.
  always @(posedge clk) begin
    if (bus.RAM_RD_EN === 1'b1) pipe[0] <= {mem_a[bus.RAM_ADDR], mem_b[bus.RAM_ADDR]};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.RAM_DATA_A = pipe[LAT-1][15:8];
  assign bus.RAM_DATA_B = pipe[LAT-1][7:0];

  // Monitors: every RAM fetch address and every Done pulse.
  always @(negedge clk) begin
    if (bus.RAM_RD_EN === 1'b1) fetch_q.push_back(int'(bus.RAM_ADDR));
    if (bus.Done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int wrap(input int x);
    return ((x % DEPTH) + DEPTH) % DEPTH;
  endfunction

  // Byte k of a transfer at RAM address a.
  function automatic logic [7:0] exp_byte(input int a, input int k, input logic chan);
`ifdef INTERLEAVE_AB_EN
    return (k % 2 == 0) ? mem_a[a] : mem_b[a];
`else
    if (k < 0) return 8'h00;
    return chan ? mem_b[a] : mem_a[a];
`endif
  endfunction

  task automatic wait_valid(input string name);
    int guard = 0;
    while (bus.Data_Valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.Data_Valid !== 1'b1) check(name, bus.Data_Valid, 1);
  endtask

  task automatic start(input int trig, input int pre, input int len, input logic chan);
    fetch_q.delete();
    done_cnt = 0;
    bus.Trig_Addr  = AW'(trig);
    bus.Pretrig    = AW'(pre);
    bus.Read_Len   = (AW + 1)'(len);
    bus.Chan_Sel   = chan;
    bus.Start_Read = 1'b1;
    @(negedge clk);
    bus.Start_Read = 1'b0;
  endtask

  task automatic pulse_rd();
    bus.MCU_RD = 1'b1;
    @(negedge clk);
    bus.MCU_RD = 1'b0;
  endtask

  // Complete transfer with random MCU hold-off; checks bytes, Done, Busy and fetches.
  task automatic run_xfer(input int trig, input int pre, input int len, input logic chan,
                          input int max_hold, output int first);
    int nbytes, got, a, hold;
    start(trig, pre, len, chan);
    nbytes = len * BPA;
    got = 0;
    while (got < nbytes) begin
      wait_valid("valid_timeout");
      if (bus.Data_Valid !== 1'b1) break;
      a = wrap(trig - pre + got / BPA);
      check("byte", bus.DATA_OUT, exp_byte(a, got, chan));
      hold = (max_hold > 0) ? int'($urandom_range(0, max_hold)) : 0;
      repeat (hold) @(negedge clk);
      if (hold > 0) check("held_byte", {bus.Data_Valid, bus.DATA_OUT}, {1'b1, exp_byte(a, got, chan)});
      pulse_rd();
      got++;
    end
    check("done_pulse", bus.Done, 1);
    @(negedge clk);
    check("busy_after_done", {bus.Busy, bus.Done}, 0);
    check("done_count", done_cnt, 1);
    check("fetch_count", fetch_q.size(), len);
    foreach (fetch_q[i]) check("fetch_addr", fetch_q[i], wrap(trig - pre + i));
    first = (fetch_q.size() > 0) ? fetch_q[0] : -1;
    $display("xfer trig=%0d pre=%0d len=%0d chan=%0d bytes=%0d first_addr=%0d fetches=%0d",
             trig, pre, len, chan, got, first, fetch_q.size());
  endtask

  typedef struct {
    int   trig;
    int   pre;
    int   len;
    logic chan;
    int   exp_start;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int first, gap, hold_bad;
    vecs[0] = '{trig: 10, pre: 3,  len: 4,  chan: 1'b0, exp_start: 7};
    vecs[1] = '{trig: 1,  pre: 3,  len: 5,  chan: 1'b1, exp_start: 14};
    vecs[2] = '{trig: 0,  pre: 0,  len: 1,  chan: 1'b0, exp_start: 0};
    vecs[3] = '{trig: 5,  pre: 15, len: 3,  chan: 1'b1, exp_start: 6};
    vecs[4] = '{trig: 15, pre: 0,  len: 2,  chan: 1'b0, exp_start: 15};
    vecs[5] = '{trig: 3,  pre: 3,  len: 16, chan: 1'b1, exp_start: 0};

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    for (int k = 0; k < LAT; k++) pipe[k] = '0;
    bus.Start_Read = 1'b0; bus.Abort = 1'b0; bus.MCU_RD = 1'b0;
    bus.Trig_Addr = '0; bus.Pretrig = '0; bus.Read_Len = '0; bus.Chan_Sel = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ram_addr", bus.RAM_ADDR, 0);
    check("rst_ram_rd_en", bus.RAM_RD_EN, 0);
    check("rst_data_out", bus.DATA_OUT, 0);
    check("rst_data_valid", bus.Data_Valid, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset released");

    // Table vectors
    foreach (vecs[i]) begin
      run_xfer(vecs[i].trig, vecs[i].pre, vecs[i].len, vecs[i].chan, 2, first);
      check("start_addr", first, vecs[i].exp_start);
    end

    // Zero length: Done two cycles after Start_Read, no RAM access
    start(5, 2, 0, 1'b0);
    check("len0_busy_setup", {bus.Busy, bus.Done}, 2'b10);
    @(negedge clk);
    check("len0_done", {bus.Busy, bus.Done}, 2'b11);
    @(negedge clk);
    check("len0_idle", {bus.Busy, bus.Done}, 2'b00);
    check("len0_no_fetch", fetch_q.size(), 0);
    $display("xfer len=0 done_pulses=%0d fetches=%0d", done_cnt, fetch_q.size());

    // Stall 20 cycles (with an ignored Start_Read), then a stray MCU_RD while invalid
    start(6, 2, 2, 1'b1);
    wait_valid("stall_valid");
    hold_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin bus.Trig_Addr = '0; bus.Start_Read = 1'b1; end
      if (c == 6) bus.Start_Read = 1'b0;
      if (bus.Data_Valid !== 1'b1 || bus.DATA_OUT !== exp_byte(4, 0, 1'b1)) hold_bad++;
      @(negedge clk);
    end
    check("stall_unstable_cycles", hold_bad, 0);
    bus.MCU_RD = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) check("rd_drops_valid", bus.Data_Valid, 0);
      bus.MCU_RD = (gap == 1);
    end while (bus.Data_Valid !== 1'b1 && gap < 50);
    bus.MCU_RD = 1'b0;
    check("valid_gap", gap, (BPA == 2) ? 2 : LAT + 2);
    for (int k = 1; k < 2 * BPA; k++) begin
      if (k > 1) wait_valid("stall_valid_k");
      check("stall_byte", bus.DATA_OUT, exp_byte(wrap(4 + k / BPA), k, 1'b1));
      pulse_rd();
    end
    check("stall_done", bus.Done, 1);
    @(negedge clk);
    check("stall_no_restart", bus.Busy, 0);
    check("stall_fetch_count", fetch_q.size(), 2);
    foreach (fetch_q[i]) check("stall_fetch_addr", fetch_q[i], 4 + i);
    $display("xfer stall gap=%0d fetches=%0d done_pulses=%0d", gap, fetch_q.size(), done_cnt);

    // Abort while the second byte is presented
    start(10, 3, 4, 1'b0);
    for (int k = 0; k < 1 + BPA; k++) begin
      wait_valid("abort_valid");
      check("abort_byte", bus.DATA_OUT, exp_byte(wrap(7 + k / BPA), k, 1'b0));
      if (k < BPA) pulse_rd();
    end
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    check("abort_outputs", {bus.Busy, bus.Data_Valid, bus.RAM_RD_EN}, 3'b000);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_fetches", fetch_q.size(), 2);
    $display("xfer abort fetches=%0d done_pulses=%0d busy=%0d", fetch_q.size(), done_cnt, bus.Busy);
    run_xfer(4, 1, 3, 1'b1, 1, first);
    check("restart_addr", first, 3);

`ifdef INTERLEAVE_AB_EN
    // Interleaved A/B bytes from one fetch per address
    mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_b[0] = 8'hA1; mem_b[1] = 8'hA2;
    run_xfer(0, 0, 2, 1'b0, 0, first);
    check("interleave_start", first, 0);
`endif

    // Random transfers against the model
    for (int t = 0; t < 8; t++) begin
      run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(1, DEPTH)), 1'($urandom_range(0, 1)), 3, first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
